// File: rtl/display_share_arbiter_pkg.sv
// Shared definitions for the display-sharing blocks: requester count, data
// width, hold-counter width and the arbiter state encoding.
package display_share_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } disp_state_t;

endpackage

// File: rtl/display_share_arbiter_rr_pick4.sv
// Combinational round-robin picker: first active request scanning from ptr
// upward, wrapping modulo the requester count.
module rr_pick4
  import display_share_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any && req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one 4-bit display register between four requesters: round-robin
// grant, one-cycle load, then a fixed hold window before re-arbitration.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [IDX_W-1:0]          owner,
  output logic                      owner_valid,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  disp_state_t      state, state_nxt;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] pick_sel;
  logic             pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = LOAD;
      LOAD:    state_nxt = HOLD;
      HOLD:    if (cnt == '0) state_nxt = pick_any ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Winner is latched on entry to LOAD so ack/reg_d depend only on registers
  // (and the selected requester's data), never on the live req vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
    end else begin
      if (state_nxt == LOAD) sel_q <= pick_sel;
      case (state)
        LOAD: begin
          owner       <= sel_q;
          owner_valid <= 1'b1;
          ptr         <= sel_q + IDX_W'(1);
          cnt         <= HOLD_INIT;
        end
        HOLD:    if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ack    = '0;
    reg_en = 1'b0;
    reg_d  = '0;
    busy   = (state != IDLE);
    if (state == LOAD) begin
      ack[sel_q] = 1'b1;
      reg_en     = 1'b1;
      reg_d      = data[32'(sel_q) * DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter: two instances (hold 3 and hold 1) share
// stimulus and are checked every cycle against a grant/busy-window model.
module tb_display_share_arbiter;

  localparam int NI = 2;
  localparam int HOLD_V [NI] = '{3, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [15:0] data = 16'h0000;

  logic [3:0] ack_w   [NI];
  logic       reg_en_w[NI];
  logic [3:0] reg_d_w [NI];
  logic [1:0] owner_w [NI];
  logic       ov_w    [NI];
  logic       busy_w  [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Model: busy cycles remaining, requester being loaded this cycle (-1 none)
  int rem_m  [NI];
  int load_m [NI];
  int ptr_m  [NI];
  int own_m  [NI];
  int ov_m   [NI];

  display_share_arbiter #(.HOLD_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack(ack_w[0]), .reg_en(reg_en_w[0]), .reg_d(reg_d_w[0]),
    .owner(owner_w[0]), .owner_valid(ov_w[0]), .busy(busy_w[0])
  );

  display_share_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack(ack_w[1]), .reg_en(reg_en_w[1]), .reg_d(reg_d_w[1]),
    .owner(owner_w[1]), .owner_valid(ov_w[1]), .busy(busy_w[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NI; u++) begin
      rem_m[u] = 0; load_m[u] = -1; ptr_m[u] = 0; own_m[u] = 0; ov_m[u] = 0;
    end
  endtask

  task automatic model_edge(input int u);
    if (load_m[u] >= 0) begin
      own_m[u] = load_m[u];
      ov_m[u]  = 1;
      ptr_m[u] = (load_m[u] + 1) % 4;
    end
    if (rem_m[u] <= 1 && req != 4'b0000) begin
      load_m[u] = pick(req, ptr_m[u]);
      rem_m[u]  = 1 + HOLD_V[u];
    end else begin
      load_m[u] = -1;
      if (rem_m[u] > 0) rem_m[u]--;
    end
  endtask

  task automatic check_all();
    logic [3:0] e_ack;
    logic [3:0] e_d;
    for (int u = 0; u < NI; u++) begin
      e_ack = 4'b0000;
      e_d   = 4'h0;
      if (load_m[u] >= 0) begin
        e_ack[load_m[u]] = 1'b1;
        e_d = data[4*load_m[u] +: 4];
      end
      check($sformatf("u%0d ack", u),         32'(ack_w[u]),    32'(e_ack));
      check($sformatf("u%0d reg_en", u),      32'(reg_en_w[u]), 32'(load_m[u] >= 0));
      check($sformatf("u%0d reg_d", u),       32'(reg_d_w[u]),  32'(e_d));
      check($sformatf("u%0d owner", u),       32'(owner_w[u]),  32'(own_m[u]));
      check($sformatf("u%0d owner_valid", u), 32'(ov_w[u]),     32'(ov_m[u]));
      check($sformatf("u%0d busy", u),        32'(busy_w[u]),   32'(rem_m[u] > 0));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) for (int u = 0; u < NI; u++) model_edge(u);
    @(negedge clk);
    check_all();
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (cycles) step();
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    run(3);
    rst = 1'b1;

    // Single requester 2 with value A
    req = 4'b0100; data = 16'h0A00;
    step();
    req = 4'b0000;
    run(7);

    // All four continuously: 0,1,2,3,0 with values F,E,D,C
    req = 4'b1111; data = 16'hCDEF;
    run(22);
    req = 4'b0000;
    run(6);

    // Withdraw requester 1 during requester 0's hold, raise requester 2
    do_reset(2);
    req = 4'b0011; data = 16'h0321;
    run(2);
    req = 4'b0101;
    run(10);
    req = 4'b0000;
    run(6);

    // Reset while loading
    do_reset(1);
    req = 4'b0001;
    step();
    do_reset(2);

    // Reset during requester 2's hold, then all request: 0 must win first
    req = 4'b0100; data = 16'h0700;
    run(3);
    do_reset(2);
    req = 4'b1111; data = 16'h4567;
    run(8);
    req = 4'b0011;
    run(10);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
          if (!req[b]) data[4*b +: 4] = 4'($urandom);
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
DISPLAY_SHARE_ARBITER -- requirements
Module: display_share_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 8, minimum number of cycles a granted value stays on the shared display before re-arbitration; legal range 1..255.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per requester i (0..3); level, held until ack or withdrawn.
REQ-005 data  input  16  requester i value on data[4i+3:4i]; stable while req[i]=1.
REQ-006 ack  output  4  one-hot grant pulse, one cycle, to the served requester.
REQ-007 reg_en  output  1  load enable for the shared 4-bit display register.
REQ-008 reg_d  output  4  value presented to the shared display register.
REQ-009 owner  output  2  index of requester whose value is currently displayed.
REQ-010 owner_valid  output  1  owner holds a meaningful value (at least one grant since reset).
REQ-011 busy  output  1  high while in LOAD or HOLD.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, HOLD; all outputs are functions of registered state (no combinational path from req to ack/reg_en).
REQ-013 IDLE: if req!=0 at an edge, the block SHALL latch winner index sel and go to LOAD; else stay IDLE.
REQ-014 Winner SHALL be round-robin: first requester with req=1 scanning ptr, ptr+1, ... ptr+3 (mod 4).
REQ-015 LOAD (exactly 1 cycle): ack[sel]=1, reg_en=1, reg_d=data[sel]; at exit edge owner<=sel, owner_valid<=1, ptr<=sel+1 (mod 4, wraps 3->0), hold counter<=HOLD_CYCLES-1; next state HOLD.
REQ-016 Latency: req sampled at edge k in IDLE -> ack high in cycle k..k+1 -> shared register captures at edge k+1.
REQ-017 HOLD: counter decrements each cycle; ack=0, reg_en=0; req ignored, including the current owner's.
REQ-018 HOLD with counter=0 at an edge: req!=0 -> arbitrate per REQ-014 and go to LOAD directly (no IDLE cycle); req=0 -> IDLE.
REQ-019 Minimum grant spacing SHALL be 1+HOLD_CYCLES cycles; with all four requesting continuously, order SHALL be 0,1,2,3,0,...
REQ-020 Requester dropping req before its ack SHALL be withdrawn: not granted, no ack, no state corruption.
REQ-021 After HOLD expires, owner/owner_valid SHALL persist until the next LOAD; the display keeps the last value.
REQ-022 reg_d SHALL be 0 whenever reg_en=0.
REQ-023 Counter 8 bits; no wrap below 0 (state leaves HOLD at 0).

Reset
REQ-024 rst=0 SHALL immediately, without clock: state IDLE, ack=0, reg_en=0, reg_d=0, owner=0, owner_valid=0, busy=0, ptr=0, counter=0.
REQ-025 Reset asserted mid-LOAD SHALL drop reg_en/ack in the same cycle; shared register is not loaded by this block.
REQ-026 After rst release the first arbitration SHALL give priority to requester 0.

Structure
REQ-027 State encoding (IDLE/LOAD/HOLD), requester count 4 and data width 4 SHALL live in a shared package used by the display blocks.
REQ-028 The round-robin winner selection SHALL be one combinational sub-module rr_pick4 (inputs req, ptr; outputs sel, any).
REQ-029 Block contains no 7-segment decode; it drives the existing register's enable/data, register output feeds the existing decoder.

Verification (HOLD_CYCLES=3 unless stated)
REQ-030 rst=0 pulse with req=1111 -> all outputs 0, busy=0 during reset, no ack.
REQ-031 req=0100, data2=A -> next cycle ack=0100, reg_en=1, reg_d=A; then owner=2, owner_valid=1, busy high 4 cycles, IDLE after.
REQ-032 req=1111 held, data=F,E,D,C for 0..3 -> acks 0001,0010,0100,1000,0001 spaced exactly 4 cycles, reg_d F,E,D,C,F.
REQ-033 req=0011; drop req[1] during requester 0 HOLD, raise req[2] -> next ack=0100, no ack to 1.
REQ-034 rst=0 during HOLD of requester 2 -> outputs cleared at once; after release req=1111 -> first ack=0001.
REQ-035 HOLD_CYCLES=1, req=0011 held -> acks alternate 0001/0010 every 2 cycles, reg_en never high two consecutive cycles.
